// File: rtl/serial_subtraction_module_8bit_pkg.sv
// Shared definitions for the bit-serial subtractor in the 8-bit ALU datapath.
//   WIDTH_DEFAULT : default operand/result width
//   state_e       : controller states (IDLE, RUN, DONE), 2-bit encoding
//   cnt_width()   : bit-counter width for a given operand width
//   CNT_W_DEFAULT : counter width for the default operand width
package serial_subtraction_module_8bit_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One extra bit so the counter can hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT) + 1;

endpackage

// File: rtl/serial_subtraction_module_8bit_full_subtractor.sv
// Single-bit full subtractor: the subtraction counterpart of the full_adder cell.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   diff : a - b - bin, modulo 2
//   bout : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtraction_module_8bit.sv
// Bit-serial two's-complement subtractor: Out = A - B, one bit per clock, LSB first.
// On signed overflow Out is forced to zero; Borrow and Overflow are still reported.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (aborts an operation in progress)
//   start    : request; operands are sampled when start=1 in IDLE or DONE
//   A, B     : minuend, subtrahend
//   Out      : registered difference (0 when Overflow=1)
//   Borrow   : registered unsigned borrow-out (A < B)
//   Overflow : registered signed overflow of A - B
//   busy     : high while a subtraction is in progress
//   done     : one-cycle completion pulse
module serial_subtraction_module_8bit
  import serial_subtraction_module_8bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Out,
  output logic             Borrow,
  output logic             Overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q;
  logic             bin_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q, b_msb_q;

  logic             accept;
  logic             last_bit;
  logic             diff, bout;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bin_q),
    .diff (diff),
    .bout (bout)
  );

  // The bit processed at this edge is the last one when the counter is
  // about to reach WIDTH.
  assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  // New difference bits enter at the MSB, so after WIDTH shifts bit 0 of the
  // result sits in bit 0.
  assign res_next = {diff, res_q[WIDTH-1:1]};

  // Signed overflow only possible when operand signs differ; detected when the
  // result sign disagrees with the minuend sign. Operand MSBs are latched at
  // accept because the shift registers have consumed them by now.
  assign ovf_next = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      Out      <= '0;
      Borrow   <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sh_q  <= A;
        b_sh_q  <= B;
        a_msb_q <= A[WIDTH-1];
        b_msb_q <= B[WIDTH-1];
        res_q   <= '0;
        bin_q   <= 1'b0;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        a_sh_q <= a_sh_q >> 1;
        b_sh_q <= b_sh_q >> 1;
        res_q  <= res_next;
        bin_q  <= bout;
        cnt_q  <= cnt_q + CW'(1);
        if (last_bit) begin
          Out      <= ovf_next ? '0 : res_next;
          Borrow   <= bout;
          Overflow <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtraction_module_8bit.sv
// Self-checking bench for serial_subtraction_module_8bit (WIDTH=8).
module tb_serial_subtraction_module_8bit;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic [WIDTH-1:0] Out;
  logic             Borrow, Overflow, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  serial_subtraction_module_8bit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .Out      (Out),
    .Borrow   (Borrow),
    .Overflow (Overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic. Returns {borrow, overflow, out}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b);
    int         sa, sb, sd;
    logic       ov, br;
    logic [7:0] d;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sd = sa - sb;
    ov = (sd > 127) || (sd < -128);
    br = (a < b);
    d  = a - b;
    return {br, ov, (ov ? 8'h00 : d)};
  endfunction

  // Issue one operation and wait for done. lat = cycles after accept edge at
  // which done was seen (-1 on timeout); bcnt = cycles with busy high.
  // Operand inputs are scrambled right after accept.
  task automatic op(input logic [7:0] a, input logic [7:0] b,
                    output int lat, output int bcnt,
                    output logic [7:0] o, output logic br, output logic ov);
    bit found;
    found = 0;
    lat = -1; bcnt = 0; o = 8'h00; br = 1'b0; ov = 1'b0;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 8'($urandom); B = 8'($urandom);
    for (int i = 1; i <= 20; i++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = i; o = Out; br = Borrow; ov = Overflow; found = 1;
        break;
      end
      @(negedge clk);
    end
    if (!found) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (Out !== 8'h00) $display("FAIL reset_out: got %h want 00", Out); else n_pass++;
    n_total++; if (Borrow !== 1'b0) $display("FAIL reset_borrow: got %b want 0", Borrow); else n_pass++;
    n_total++; if (Overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", Overflow); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] ta[5] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h40};
    logic [7:0] tb[5] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h20};
    logic [7:0] to[5] = '{8'h02, 8'hFE, 8'h00, 8'h00, 8'h20};
    logic       tbr[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       tov[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat, bcnt;
    logic [7:0] o;
    logic br, ov;
    for (int i = 0; i < 5; i++) begin
      op(ta[i], tb[i], lat, bcnt, o, br, ov);
      n_total++; if (lat != 9) $display("FAIL dir%0d_latency: got %0d want 9", i, lat); else n_pass++;
      n_total++; if (bcnt != 8) $display("FAIL dir%0d_busy_cycles: got %0d want 8", i, bcnt); else n_pass++;
      n_total++; if (o !== to[i]) $display("FAIL dir%0d_out: got %h want %h", i, o, to[i]); else n_pass++;
      n_total++; if (br !== tbr[i]) $display("FAIL dir%0d_borrow: got %b want %b", i, br, tbr[i]); else n_pass++;
      n_total++; if (ov !== tov[i]) $display("FAIL dir%0d_ovf: got %b want %b", i, ov, tov[i]); else n_pass++;
      @(negedge clk);
      n_total++; if (done !== 1'b0) $display("FAIL dir%0d_done_width: got %b want 0", i, done); else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    int dcount, dcyc;
    logic [7:0] o;
    dcount = 0; dcyc = -1; o = 8'h00;
    @(negedge clk);
    A = 8'h10; B = 8'h01; start = 1'b1;
    @(negedge clk); start = 1'b0;               // cycle 1 of RUN
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin start = 1'b1; A = 8'hFF; B = 8'hFF; end
      if (c == 4) begin start = 1'b0; A = 8'h00; B = 8'h00; end
      if (done) begin
        dcount++;
        if (dcyc < 0) begin dcyc = c; o = Out; end
      end
      @(negedge clk);
    end
    n_total++; if (dcount != 1) $display("FAIL ign_done_count: got %0d want 1", dcount); else n_pass++;
    n_total++; if (dcyc != 9) $display("FAIL ign_latency: got %0d want 9", dcyc); else n_pass++;
    n_total++; if (o !== 8'h0F) $display("FAIL ign_out: got %h want 0f", o); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int dcount, lat, bcnt;
    logic [7:0] o;
    logic br, ov;
    dcount = 0;
    @(negedge clk);
    A = 8'h40; B = 8'h20; start = 1'b1;
    @(negedge clk); start = 1'b0;               // cycle 1 of RUN
    repeat (3) @(negedge clk);                  // cycle 4 of RUN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else n_pass++;
    n_total++; if (Out !== 8'h00) $display("FAIL abort_out: got %h want 00", Out); else n_pass++;
    n_total++; if (Borrow !== 1'b0) $display("FAIL abort_borrow: got %b want 0", Borrow); else n_pass++;
    n_total++; if (Overflow !== 1'b0) $display("FAIL abort_ovf: got %b want 0", Overflow); else n_pass++;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    n_total++; if (dcount != 0) $display("FAIL abort_no_done: got %0d pulses want 0", dcount); else n_pass++;
    op(8'h40, 8'h20, lat, bcnt, o, br, ov);
    n_total++; if (lat != 9) $display("FAIL abort_restart_latency: got %0d want 9", lat); else n_pass++;
    n_total++; if (o !== 8'h20) $display("FAIL abort_restart_out: got %h want 20", o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    bit found;
    found = 0;
    @(negedge clk);
    A = 8'h33; B = 8'h11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin found = 1; break; end
      @(negedge clk);
    end
    n_total++; if (!found) $display("FAIL b2b_first_done: got timeout want pulse"); else n_pass++;
    n_total++; if (Out !== 8'h22) $display("FAIL b2b_first_out: got %h want 22", Out); else n_pass++;
    // Still in the done cycle: request the next operation immediately.
    A = 8'h00; B = 8'h01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = -1; bcnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) bcnt++;
      if (done) begin lat = c; break; end
      @(negedge clk);
    end
    n_total++; if (lat != 9) $display("FAIL b2b_latency: got %0d want 9", lat); else n_pass++;
    n_total++; if (bcnt != 8) $display("FAIL b2b_busy_cycles: got %0d want 8", bcnt); else n_pass++;
    n_total++; if (Out !== 8'hFF) $display("FAIL b2b_out: got %h want ff", Out); else n_pass++;
    n_total++; if (Borrow !== 1'b1) $display("FAIL b2b_borrow: got %b want 1", Borrow); else n_pass++;
    n_total++; if (Overflow !== 1'b0) $display("FAIL b2b_ovf: got %b want 0", Overflow); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b0) $display("FAIL b2b_done_width: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic [7:0] a, b, o;
    logic br, ov;
    logic [9:0] exp_v;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      exp_v = model(a, b);
      op(a, b, lat, bcnt, o, br, ov);
      n_total++; if (lat != 9) $display("FAIL rnd%0d_latency: a=%h b=%h got %0d want 9", i, a, b, lat); else n_pass++;
      n_total++; if ({br, ov, o} !== exp_v)
        $display("FAIL rnd%0d_result: a=%h b=%h got br=%b ov=%b out=%h want br=%b ov=%b out=%h",
                 i, a, b, br, ov, o, exp_v[9], exp_v[8], exp_v[7:0]);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00;
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
